gray_to_bin_seq: RTL and testbench
==================================

GRAY_TO_BIN_SEQ -- requirements
Module: gray_to_bin_seq

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the code word width in bits (N >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: in_gray holds a word to decode.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept a word.
REQ-006 The block SHALL have port in_gray, input, N bits: the Gray-coded input word.
REQ-007 The block SHALL have port out_valid, output, 1 bit: out_bin holds a decoded result.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-009 The block SHALL have port out_bin, output, N bits: the decoded binary word.
REQ-010 The block SHALL have port busy, output, 1 bit: high while state is BUSY.

Function
REQ-011 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-012 in_ready SHALL be high only in IDLE, and out_valid SHALL be high only in DONE; the block SHALL never overlap two words.
REQ-013 An input SHALL be accepted on a rising edge with in_valid=1 and in_ready=1; in_gray is captured and the FSM moves IDLE->BUSY with bit index i=N-1.
REQ-014 In BUSY, each cycle SHALL resolve one bit, MSB first: B[N-1]=G[N-1] and B[i]=B[i+1] XOR G[i]; i decrements by 1 per edge.
REQ-015 After bit 0 resolves (N edges after the accept edge), the FSM SHALL enter DONE with out_valid=1 and out_bin equal to the full binary word.
REQ-016 In DONE with out_ready=0, out_valid and out_bin SHALL remain stable.
REQ-017 On an edge with out_valid=1 and out_ready=1, the FSM SHALL return to IDLE.
REQ-018 With in_valid and out_ready held high, throughput SHALL be one word per N+2 cycles.
REQ-019 in_gray SHALL be ignored except on the accept edge, and out_ready SHALL be ignored outside DONE.
REQ-020 out_bin SHALL retain the last decoded word after the DONE->IDLE transition until the next DONE.
REQ-021 The bit index counter SHALL be clog2(N) bits wide and SHALL never wrap below 0.

Reset
REQ-022 When rst_n=0 on a rising edge, state SHALL become IDLE; out_valid, busy, out_bin, the index and the captured word SHALL clear to 0; in_ready SHALL be 1 in the cycle after reset.
REQ-023 A reset asserted in BUSY or DONE SHALL abandon the in-flight word with no output handshake.
REQ-024 Reset SHALL take priority over all handshakes on the same edge.

Configuration
REQ-025 When macro G2B_ADJ_CHECK_EN is defined, the block SHALL add an output port adj_err (1 bit), a register holding the previous accepted word, and a prev-valid flag.
REQ-026 With G2B_ADJ_CHECK_EN defined, adj_err SHALL be valid in DONE and equal 1 iff prev-valid=1 and the current and previous accepted words differ in a number of bits other than exactly one (identical words are an error).
REQ-027 With G2B_ADJ_CHECK_EN defined, the first word after reset SHALL never flag; reset SHALL clear adj_err, the previous-word register and prev-valid.
REQ-028 Without G2B_ADJ_CHECK_EN, the block SHALL have no adj_err port and no comparison logic, and all other behaviour SHALL be identical.

Verification (N=4)
REQ-029 Accept in_gray=0111 with out_ready=1 -> out_valid rises 4 edges after accept with out_bin=0101; busy is high for exactly 4 cycles.
REQ-030 Sequence 0000 then 1000 -> out_bin=0000, then 1111; in_ready stays low from each accept until the DONE handshake.
REQ-031 Hold out_ready=0 for 5 cycles in DONE with in_valid=1 and in_gray changing -> out_bin holds, in_ready stays 0, and no second accept occurs.
REQ-032 Assert rst_n=0 two cycles after accepting 1010 -> out_valid is never seen for that word; all outputs are 0 and in_ready is 1 after reset.
REQ-033 Decode all 16 Gray codes back to back -> each out_bin matches the reference Gray-to-binary model and the period is 6 cycles.
REQ-034 With G2B_ADJ_CHECK_EN, send 0000, 0001, 0111, 0111 -> adj_err reads 0, 0, 1, 1.

Source files
------------

// File: rtl/gray_to_bin_seq.sv
// gray_to_bin_seq: sequential Gray-to-binary decoder, one bit per cycle, MSB first
// Ports: clk, rst_n (sync, active low); in_valid/in_ready/in_gray accept a word in IDLE;
//        out_valid/out_ready/out_bin present the result in DONE; busy marks BUSY.
// Optional: define G2B_ADJ_CHECK_EN to add adj_err, flagging a non-unit Hamming step
//           between consecutive accepted words.
module gray_to_bin_seq #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_gray,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_bin,
   output logic         busy
`ifdef G2B_ADJ_CHECK_EN
   ,
   output logic         adj_err
`endif
);
   localparam int IW = $clog2(N);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [N-1:0]  gray_q, gray_d, work_q, work_d, bin_q, bin_d, step;
   logic          accept, last;
   assign accept = (state_q == IDLE) && in_valid;
   assign last   = (idx_q == '0);
   // work_q shifts left; its LSB always holds the previously resolved bit B[i+1]
   // (zero before the first step), so the new bit is work_q[0] ^ G[i].
   assign step   = {work_q[N-2:0], work_q[0] ^ gray_q[idx_q]};
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         gray_q  <= '0;
         work_q  <= '0;
         bin_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         gray_q  <= gray_d;
         work_q  <= work_d;
         bin_q   <= bin_d;
      end
   end
   always_comb begin
      state_d = accept                        ? BUSY :
                (state_q == BUSY && last)     ? DONE :
                (state_q == DONE && out_ready) ? IDLE : state_q;
   end
   always_comb begin
      gray_d = accept ? in_gray : gray_q;
      idx_d  = accept ? IW'(N - 1) : (state_q == BUSY && !last) ? idx_q - 1'b1 : idx_q;
      work_d = accept ? '0 : (state_q == BUSY) ? step : work_q;
      // out_bin only changes when the full word is ready, so it keeps the last result
      bin_d  = (state_q == BUSY && last) ? step : bin_q;
   end
   always_comb begin
      in_ready  = (state_q == IDLE);
      busy      = (state_q == BUSY);
      out_valid = (state_q == DONE);
      out_bin   = bin_q;
   end
`ifdef G2B_ADJ_CHECK_EN
   logic [N-1:0] prev_q, prev_d;
   logic         prev_vld_q, prev_vld_d, adj_q, adj_d;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_q     <= '0;
         prev_vld_q <= 1'b0;
         adj_q      <= 1'b0;
      end else begin
         prev_q     <= prev_d;
         prev_vld_q <= prev_vld_d;
         adj_q      <= adj_d;
      end
   end
   always_comb begin
      prev_d     = accept ? in_gray : prev_q;
      prev_vld_d = accept ? 1'b1 : prev_vld_q;
      adj_d      = accept ? (prev_vld_q && ($countones(in_gray ^ prev_q) != 1)) : adj_q;
   end
   assign adj_err = adj_q;
`endif
endmodule

// File: tb/tb_gray_to_bin_seq.sv
// tb_gray_to_bin_seq: directed self-checking bench for gray_to_bin_seq (N=4)
module tb_gray_to_bin_seq;
   logic       clk = 1'b0;
   logic       rst_n, in_valid, in_ready, out_valid, out_ready, busy;
   logic [3:0] in_gray, out_bin;
   int         checks = 0, failures = 0;
`ifdef G2B_ADJ_CHECK_EN
   logic       adj_err;
`endif
   gray_to_bin_seq #(.N(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_gray(in_gray), .out_valid(out_valid), .out_ready(out_ready),
      .out_bin(out_bin), .busy(busy)
`ifdef G2B_ADJ_CHECK_EN
      , .adj_err(adj_err)
`endif
   );
   always #5 clk = ~clk;
   // Stimulus only: accept g from IDLE and return at the first negedge with out_valid
   // (or after a bound), reporting latency in edges, busy cycles and whether in_ready rose.
   task automatic xfer(input logic [3:0] g, output logic [3:0] res, output int lat,
                       output int bsy, output logic rdy);
      in_valid = 1'b1;
      in_gray  = g;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0; bsy = 0; rdy = 1'b0;
      while (!out_valid && lat < 20) begin
         rdy |= in_ready;
         bsy += int'(busy);
         @(negedge clk);
         lat++;
      end
      rdy |= in_ready;
      res = out_bin;
   endtask
   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_gray = 4'h0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      checks += 4;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      if (out_bin !== 4'h0) begin failures++; $display("FAIL reset_out_bin got=%h exp=0", out_bin); end
   endtask
   task automatic test_decode();
      logic [3:0] r; int lat, bsy; logic rdy;
      out_ready = 1'b1;
      xfer(4'b0111, r, lat, bsy, rdy);
      checks += 4;
      if (lat != 4) begin failures++; $display("FAIL decode_latency got=%0d exp=4", lat); end
      if (bsy != 4) begin failures++; $display("FAIL decode_busy_cycles got=%0d exp=4", bsy); end
      if (r !== 4'b0101) begin failures++; $display("FAIL decode_out_bin got=%b exp=0101", r); end
      if (rdy !== 1'b0) begin failures++; $display("FAIL decode_in_ready_low got=%b exp=0", rdy); end
      @(negedge clk);
      checks += 3;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL decode_back_idle got=%b exp=1", in_ready); end
      if (out_valid !== 1'b0) begin failures++; $display("FAIL decode_valid_drop got=%b exp=0", out_valid); end
      if (out_bin !== 4'b0101) begin failures++; $display("FAIL decode_bin_retained got=%b exp=0101", out_bin); end
   endtask
   task automatic test_pair();
      logic [3:0] r; int lat, bsy; logic rdy;
      logic [3:0] gv [2] = '{4'b0000, 4'b1000};
      logic [3:0] bv [2] = '{4'b0000, 4'b1111};
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         xfer(gv[i], r, lat, bsy, rdy);
         checks += 3;
         if (r !== bv[i]) begin failures++; $display("FAIL pair%0d_out_bin got=%b exp=%b", i, r, bv[i]); end
         if (lat != 4) begin failures++; $display("FAIL pair%0d_latency got=%0d exp=4", i, lat); end
         if (rdy !== 1'b0) begin failures++; $display("FAIL pair%0d_in_ready_low got=%b exp=0", i, rdy); end
         @(negedge clk);
      end
   endtask
   task automatic test_stall();
      logic [3:0] r; int lat, bsy; logic rdy;
      out_ready = 1'b0;
      xfer(4'b0011, r, lat, bsy, rdy);
      checks++;
      if (r !== 4'b0010) begin failures++; $display("FAIL stall_out_bin got=%b exp=0010", r); end
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_gray = 4'(i * 3 + 5);
         @(negedge clk);
         checks += 4;
         if (out_valid !== 1'b1) begin failures++; $display("FAIL stall%0d_out_valid got=%b exp=1", i, out_valid); end
         if (out_bin !== 4'b0010) begin failures++; $display("FAIL stall%0d_out_bin got=%b exp=0010", i, out_bin); end
         if (in_ready !== 1'b0) begin failures++; $display("FAIL stall%0d_in_ready got=%b exp=0", i, in_ready); end
         if (busy !== 1'b0) begin failures++; $display("FAIL stall%0d_busy got=%b exp=0", i, busy); end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      checks += 2;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_release got=%b exp=1", in_ready); end
      if (out_bin !== 4'b0010) begin failures++; $display("FAIL stall_bin_retained got=%b exp=0010", out_bin); end
   endtask
   task automatic test_abort();
      logic seen = 1'b0;
      out_ready = 1'b1;
      in_valid = 1'b1; in_gray = 4'b1010;
      @(negedge clk);
      in_valid = 1'b0;
      seen |= out_valid;
      @(negedge clk);
      seen |= out_valid;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks += 4;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL abort_in_ready got=%b exp=1", in_ready); end
      if (out_valid !== 1'b0) begin failures++; $display("FAIL abort_out_valid got=%b exp=0", out_valid); end
      if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
      if (out_bin !== 4'h0) begin failures++; $display("FAIL abort_out_bin got=%h exp=0", out_bin); end
      repeat (6) begin
         @(negedge clk);
         seen |= out_valid;
      end
      checks++;
      if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_output got=%b exp=0", seen); end
   endtask
   task automatic test_back_to_back();
      int cyc = 0, nout = 0, nin = 1, last = -1;
      logic [3:0] k;
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_gray = 4'h0;
      while (nout < 16 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (out_valid) begin
            k = 4'(nout);
            checks++;
            if (out_bin !== k) begin failures++; $display("FAIL b2b_bin%0d got=%b exp=%b", nout, out_bin, k); end
            if (last >= 0) begin
               checks++;
               if (cyc - last != 6) begin failures++; $display("FAIL b2b_period%0d got=%0d exp=6", nout, cyc - last); end
            end
            last = cyc;
            nout++;
         end
         if (in_ready) begin
            if (nin < 16) begin
               k = 4'(nin);
               in_gray = k ^ (k >> 1);
               nin++;
            end else in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      checks++;
      if (nout != 16) begin failures++; $display("FAIL b2b_count got=%0d exp=16", nout); end
      repeat (8) @(negedge clk);
   endtask
`ifdef G2B_ADJ_CHECK_EN
   task automatic test_adj();
      logic [3:0] r; int lat, bsy; logic rdy;
      logic [3:0] gv [4] = '{4'b0000, 4'b0001, 4'b0111, 4'b0111};
      logic       ev [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks++;
      if (adj_err !== 1'b0) begin failures++; $display("FAIL adj_reset got=%b exp=0", adj_err); end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         xfer(gv[i], r, lat, bsy, rdy);
         checks++;
         if (adj_err !== ev[i]) begin failures++; $display("FAIL adj%0d got=%b exp=%b", i, adj_err, ev[i]); end
         @(negedge clk);
      end
   endtask
`endif
   initial begin
      test_reset();
      test_decode();
      test_pair();
      test_stall();
      test_abort();
      test_back_to_back();
`ifdef G2B_ADJ_CHECK_EN
      test_adj();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
